// File: rtl/fp_pkg.sv
// fp_pkg: shared widths, packed constants, FSM states and raw-mantissa bit positions for the FP normalise/round stage
package fp_pkg;
  localparam int EXP_W = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS = 127;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF = 32'hFF80_0000;
  localparam logic [31:0] ZERO = 32'h0000_0000;
  localparam int CARRY = FRAC_W + 4;
  localparam int HIDDEN = FRAC_W + 3;
  localparam int G = 2;
  localparam int R = 1;
  localparam int S = 0;
  typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_t;
endpackage

// File: rtl/fp_round_rne.sv
// fp_round_rne: round-to-nearest-even of {hidden,frac,G,R,S}; ports: mant in, rounded (carry,hidden,frac) out, carry out, inexact out
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [FRAC_W+3:0] mant,
  output logic [FRAC_W+1:0] rounded,
  output logic              carry,
  output logic              inexact
);
  logic inc;
  assign inc = mant[G] & (mant[R] | mant[S] | mant[G+1]);
  assign rounded = {1'b0, mant[FRAC_W+3:3]} + (FRAC_W+2)'(inc);
  assign carry = rounded[FRAC_W+1];
  assign inexact = |mant[G:S];
endmodule

// File: rtl/fp_norm_round.sv
// fp_norm_round: normalise, RNE-round and pack a raw adder sum into an IEEE single; ports: clk, rst_n, in_* (valid/ready, sign, exp, mant), out_* (valid/ready, result, overflow, underflow, inexact)
module fp_norm_round
  import fp_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sign,
  input  logic [EXP_W+1:0]    in_exp,
  input  logic [FRAC_W+4:0]   in_mant,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_result,
  output logic                out_overflow,
  output logic                out_underflow,
  output logic                out_inexact
);
  localparam int XW = EXP_W + 2;
  state_t state;
  logic sgn;
  logic [XW-1:0] ex;
  logic [FRAC_W+4:0] mt;
  logic [FRAC_W+1:0] rounded;
  logic carry, inexact, hid_r;
  logic [FRAC_W-1:0] frac_r;
  logic [XW-1:0] exp_r;
  fp_round_rne u_rnd (.mant(mt[FRAC_W+3:0]), .rounded(rounded), .carry(carry), .inexact(inexact));
  // a rounding carry-out means the mantissa became 10.000..0; renormalise by one
  assign frac_r = carry ? rounded[FRAC_W:1] : rounded[FRAC_W-1:0];
  assign hid_r = carry | rounded[FRAC_W];
  assign exp_r = ex + XW'(carry);
  assign in_ready = rst_n && state == IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sgn <= 1'b0;
      ex <= '0;
      mt <= '0;
      out_valid <= 1'b0;
      out_result <= ZERO;
      out_overflow <= 1'b0;
      out_underflow <= 1'b0;
      out_inexact <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sgn <= in_sign;
          ex <= in_exp;
          mt <= in_mant;
          out_overflow <= 1'b0;
          out_underflow <= 1'b0;
          out_inexact <= 1'b0;
          if (in_mant == '0) begin
            out_result <= {in_sign, 31'b0};
            out_valid <= 1'b1;
            state <= OUT;
          end else if (in_exp >= XW'(EXP_MAX)) begin
            out_result <= in_sign ? NEG_INF : POS_INF;
            out_overflow <= 1'b1;
            out_valid <= 1'b1;
            state <= OUT;
          end else if (in_exp == '0) begin
            out_result <= {in_sign, 31'b0};
            out_underflow <= 1'b1;
            out_valid <= 1'b1;
            state <= OUT;
          end else begin
            state <= NORM;
          end
        end
        NORM: if (mt[CARRY]) begin
          // right shift folds the dropped bit into sticky
          mt <= {1'b0, mt[FRAC_W+4:2], |mt[R:S]};
          ex <= ex + XW'(1);
          state <= ROUND;
        end else if (!mt[HIDDEN] && ex > XW'(1)) begin
          mt <= mt << 1;
          ex <= ex - XW'(1);
        end else begin
          state <= ROUND;
        end
        ROUND: begin
          out_inexact <= inexact;
          out_valid <= 1'b1;
          state <= OUT;
          if (exp_r >= XW'(EXP_MAX)) begin
            out_result <= sgn ? NEG_INF : POS_INF;
            out_overflow <= 1'b1;
          end else if (!hid_r) begin
            out_result <= {sgn, 31'b0};
            out_underflow <= 1'b1;
          end else begin
            out_result <= {sgn, exp_r[EXP_W-1:0], frac_r};
          end
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_norm_round.sv
// tb_fp_norm_round: scoreboard bench driving directed raw sums and checking result, flags and latency
module tb_fp_norm_round;
  logic clk = 0;
  logic rst_n = 0;
  logic in_valid = 0;
  logic in_ready;
  logic in_sign = 0;
  logic [9:0] in_exp = 0;
  logic [27:0] in_mant = 0;
  logic out_valid;
  logic out_ready = 1;
  logic [31:0] out_result;
  logic out_overflow, out_underflow, out_inexact;
  typedef struct {
    logic [31:0] res;
    logic [2:0] fl;
    int lat;
    int acc;
  } exp_t;
  exp_t q[$];
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  logic pv = 0;

  fp_norm_round dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_overflow(out_overflow), .out_underflow(out_underflow), .out_inexact(out_inexact)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // flags are packed {overflow, underflow, inexact}; latency counts cycles from acceptance to first visible out_valid
  always @(negedge clk) begin
    if (out_valid && !pv) begin
      if (q.size() == 0) chk("no_expected_output", 32'(out_valid), 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("result", out_result, e.res);
        chk("flags", {29'b0, out_overflow, out_underflow, out_inexact}, {29'b0, e.fl});
        chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end
    pv = out_valid;
  end

  task automatic send(input logic s, input logic [9:0] e, input logic [27:0] m,
                      input logic [31:0] r, input logic [2:0] f, input int lat);
    int n = 0;
    @(negedge clk);
    in_sign = s;
    in_exp = e;
    in_mant = m;
    in_valid = 1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    else q.push_back('{r, f, lat, cyc + 1});
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || !in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_flags", {29'b0, out_overflow, out_underflow, out_inexact}, 32'd0);
    chk("rst_in_ready_low", 32'(in_ready), 32'd0);
    rst_n = 1;
    @(negedge clk);
    chk("rst_in_ready_release", 32'(in_ready), 32'd1);

    send(0, 10'd127, 28'h8000000, 32'h40000000, 3'b000, 3);  drain();
    send(0, 10'd127, 28'h0800000, 32'h3E000000, 3'b000, 6);  drain();
    send(0, 10'd127, 28'h4000004, 32'h3F800000, 3'b001, 3);  drain();
    send(0, 10'd127, 28'h400000C, 32'h3F800002, 3'b001, 3);  drain();
    send(0, 10'd254, 28'h7FFFFFF, 32'h7F800000, 3'b101, 3);  drain();
    send(0, 10'd300, 28'h1234567, 32'h7F800000, 3'b100, 1);  drain();
    send(1, 10'd1,   28'h2000000, 32'h80000000, 3'b010, 3);  drain();
    send(1, 10'd100, 28'h0000000, 32'h80000000, 3'b000, 1);  drain();
    send(0, 10'd0,   28'h0000123, 32'h00000000, 3'b010, 1);  drain();
    send(0, 10'd127, 28'h0000001, 32'h32800000, 3'b000, 29); drain();
    send(0, 10'd127, 28'h8000003, 32'h40000000, 3'b001, 3);  drain();
    send(1, 10'd130, 28'h6000000, 32'hC1400000, 3'b000, 3);  drain();

    out_ready = 0;
    send(0, 10'd127, 28'h8000000, 32'h40000000, 3'b000, 3);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("stall_timeout", 32'd0, 32'd1);
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_result", out_result, 32'h40000000);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1;
    @(negedge clk);
    chk("handshake_valid_drop", 32'(out_valid), 32'd0);
    chk("handshake_in_ready", 32'(in_ready), 32'd1);

    @(negedge clk);
    in_exp = 10'd127;
    in_mant = 28'h0800000;
    in_sign = 0;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1;
    @(negedge clk);
    chk("midrst_in_ready_release", 32'(in_ready), 32'd1);
    repeat (8) begin
      @(negedge clk);
      chk("midrst_no_stale", 32'(out_valid), 32'd0);
    end
    send(0, 10'd127, 28'h8000000, 32'h40000000, 3'b000, 3); drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
